// File: rtl/stage_if_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package stage_if_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_t;

endpackage

// File: rtl/stage_if.sv
// Instruction-fetch stage: reads a 32-bit word one byte at a time from the memory
// controller, presents it to if_id as a one-cycle get_inst pulse and advances the PC.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        get_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  fsm_state
);

    // Memory handshake: mem_req_o/mem_addr_o are held until a cycle with mem_gnt_i high
    // accepts the request; exactly one mem_rvalid_i/mem_rdata_i answers it at least one
    // cycle later. Only one byte transaction is ever outstanding.

    if_state_t   state;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic        in_flight;
    logic        unused_ok;

    assign unused_ok = ^{stall[5:1], branch_target_i[1:0]};

    // A granted byte is still owed by the controller until its rvalid arrives.
    assign in_flight = (state == IF_WAIT) || (state == IF_DRAIN) ||
                       ((state == IF_FETCH) && mem_gnt_i);

    assign mem_req_o  = (state == IF_FETCH) && !rst;
    assign mem_addr_o = pc + {30'd0, byte_cnt};
    assign fsm_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IF_FETCH;
            pc       <= RESET_PC;
            byte_cnt <= 2'd0;
            word_buf <= ZERO_WORD;
            get_inst <= 1'b0;
            if_pc    <= ZERO_WORD;
            if_inst  <= ZERO_WORD;
        end else begin
            get_inst <= 1'b0;
            if (branch_flag_i) begin
                pc       <= {branch_target_i[31:2], 2'b00};
                byte_cnt <= 2'd0;
                word_buf <= ZERO_WORD;
                state    <= (in_flight && !mem_rvalid_i) ? IF_DRAIN : IF_FETCH;
            end else begin
                case (state)
                    IF_FETCH: begin
                        if (mem_gnt_i) begin
                            state <= IF_WAIT;
                        end
                    end
                    IF_WAIT: begin
                        if (mem_rvalid_i) begin
                            if (byte_cnt != 2'd3) begin
                                word_buf[{byte_cnt, 3'b000} +: 8] <= mem_rdata_i;
                                byte_cnt <= byte_cnt + 2'd1;
                                state    <= IF_FETCH;
                            end else begin
                                byte_cnt          <= 2'd0;
                                word_buf[31:24]   <= mem_rdata_i;
                                if (stall[0] == NO_STOP) begin
                                    get_inst <= 1'b1;
                                    if_pc    <= pc;
                                    if_inst  <= {mem_rdata_i, word_buf[23:0]};
                                    pc       <= pc + 32'd4;
                                    state    <= IF_FETCH;
                                end else begin
                                    state <= IF_HOLD;
                                end
                            end
                        end
                    end
                    IF_HOLD: begin
                        if (stall[0] == NO_STOP) begin
                            get_inst <= 1'b1;
                            if_pc    <= pc;
                            if_inst  <= word_buf;
                            pc       <= pc + 32'd4;
                            state    <= IF_FETCH;
                        end
                    end
                    IF_DRAIN: begin
                        if (mem_rvalid_i) begin
                            state <= IF_FETCH;
                        end
                    end
                    default: state <= IF_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: byte-wide memory responder, table vectors, directed corner
// sequences and a randomized run checked against an instruction-stream model.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [7:0]  mem_rdata_i = 8'd0;
    logic        get_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  fsm_state;

    stage_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .get_inst(get_inst), .if_pc(if_pc), .if_inst(if_inst), .fsm_state(fsm_state)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory image: a fixed program at 0..3, an address-derived byte elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h00;
            32'd2:   return 8'h50;
            32'd3:   return 8'h00;
            default: return a[7:0] + 8'h10;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory controller model ----------------
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    int          gnt_pct = 100;
    int          fixed_lat = 1;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    task automatic mem_step();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_byte(pend_addr);
                pend = 1'b0;
                rv_cnt++;
            end
        end else if (mem_req_o && ($urandom_range(99) < gnt_pct)) begin
            mem_gnt_i = 1'b1;
            pend      = 1'b1;
            pend_addr = mem_addr_o;
            pend_cnt  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 1));
            gnt_cnt++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mem_step();
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 6'd0;
        branch_flag_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        gnt_cnt = 0;
        rv_cnt = 0;
    endtask

    task automatic wait_gnt(input int n);
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick();
            if (gnt_cnt >= n) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_gnt: got %0d grants expected %0d", gnt_cnt, n);
        end
    endtask

    task automatic wait_pulse(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_inst);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (get_inst === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no get_inst expected pc %h", name, exp_pc);
        end else begin
            check({name, "_pc"}, if_pc, exp_pc);
            check({name, "_inst"}, if_inst, exp_inst);
        end
    endtask

    typedef struct {
        logic [31:0] target;
        int          stall_cycles;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc2;
        logic [31:0] exp_inst2;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic        prev_pulse;
        logic        st;
        logic        br;
        int          pulses;

        vecs[0] = '{32'h0000_0103, 0,  32'h0000_0100, 32'h1312_1110, 32'h0000_0104, 32'h1716_1514};
        vecs[1] = '{32'h0000_0020, 3,  32'h0000_0020, 32'h3332_3130, 32'h0000_0024, 32'h3736_3534};
        vecs[2] = '{32'hFFFF_FFFE, 0,  32'hFFFF_FFFC, 32'h0F0E_0D0C, 32'h0000_0000, 32'h0050_0013};
        vecs[3] = '{32'h0000_0042, 10, 32'h0000_0040, 32'h5352_5150, 32'h0000_0044, 32'h5756_5554};
        vecs[4] = '{32'h0000_0004, 0,  32'h0000_0004, 32'h1716_1514, 32'h0000_0008, 32'h1B1A_1918};

        // Reset state while rst is held high.
        tick();
        check("rst_get_inst", get_inst, 1'b0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_mem_req", mem_req_o, 1'b0);

        // First word after reset, then the next request address.
        gnt_pct = 100; fixed_lat = 1;
        do_reset();
        check("first_req_addr", mem_addr_o, 32'd0);
        wait_pulse("first", 32'd0, 32'h0050_0013);
        check("first_next_req", mem_req_o, 1'b1);
        check("first_next_addr", mem_addr_o, 32'd4);

        // Three back-to-back words.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_pulse("b2b", 32'(i * 4), word_at(32'(i * 4)));
            tick();
            check("b2b_no_repeat", get_inst, 1'b0);
        end

        // Stall raised before the 4th byte arrives.
        do_reset();
        wait_gnt(4);
        stall = 6'h01;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_no_pulse", get_inst, 1'b0);
            check("stall_no_req", mem_req_o, 1'b0);
        end
        stall = 6'h00;
        tick();
        check("stall_release_pulse", get_inst, 1'b1);
        check("stall_release_pc", if_pc, 32'd0);
        check("stall_release_inst", if_inst, 32'h0050_0013);
        check("stall_next_addr", mem_addr_o, 32'd4);

        // Branch while waiting for byte 2: in-flight byte must be drained.
        fixed_lat = 3;
        do_reset();
        wait_gnt(3);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0103;
        tick();
        branch_flag_i = 1'b0;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                check("drain_no_pulse", get_inst, 1'b0);
                if (mem_req_o === 1'b1) seen = 1'b1;
                else tick();
            end
            check("drain_req_seen", seen, 1'b1);
            check("drain_req_addr", mem_addr_o, 32'h0000_0100);
        end
        wait_pulse("drain_word", 32'h0000_0100, 32'h1312_1110);

        // Branch in the same cycle as the 4th byte's rvalid.
        fixed_lat = 1;
        do_reset();
        wait_gnt(4);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0200;
        tick();
        branch_flag_i = 1'b0;
        check("brv_no_pulse", get_inst, 1'b0);
        check("brv_req", mem_req_o, 1'b1);
        check("brv_addr", mem_addr_o, 32'h0000_0200);
        wait_pulse("brv_word", 32'h0000_0200, 32'h1312_1110);

        // Reset asserted mid-WAIT.
        wait_gnt(gnt_cnt + 1);
        rst = 1'b1;
        #1;
        check("midrst_get_inst", get_inst, 1'b0);
        check("midrst_if_pc", if_pc, 32'd0);
        check("midrst_if_inst", if_inst, 32'd0);
        check("midrst_req", mem_req_o, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_first_req", mem_req_o, 1'b1);
        check("midrst_first_addr", mem_addr_o, 32'd0);

        // Table vectors under random memory timing.
        gnt_pct = 70; fixed_lat = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            branch_flag_i = 1'b1;
            branch_target_i = vecs[i].target;
            stall = (vecs[i].stall_cycles > 0) ? 6'h01 : 6'h00;
            tick();
            branch_flag_i = 1'b0;
            check("vec_no_pulse_at_branch", get_inst, 1'b0);
            for (int c = 0; c < vecs[i].stall_cycles; c++) begin
                tick();
                check("vec_stalled_no_pulse", get_inst, 1'b0);
            end
            stall = 6'h00;
            wait_pulse("vec_a", vecs[i].exp_pc, vecs[i].exp_inst);
            wait_pulse("vec_b", vecs[i].exp_pc2, vecs[i].exp_inst2);
        end

        // Randomized run against the instruction-stream model.
        do_reset();
        exp_pc = 32'd0;
        held_pc = 32'd0;
        held_inst = 32'd0;
        prev_pulse = 1'b0;
        st = 1'b0;
        br = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (get_inst === 1'b1) begin
                check("rnd_pulse_while_stalled", st, 1'b0);
                check("rnd_pulse_on_branch", br, 1'b0);
                check("rnd_pulse_repeat", prev_pulse, 1'b0);
                check("rnd_pc", if_pc, exp_pc);
                check("rnd_inst", if_inst, word_at(exp_pc));
                held_pc = exp_pc;
                held_inst = word_at(exp_pc);
                exp_pc = exp_pc + 32'd4;
                pulses++;
            end else begin
                check("rnd_hold_pc", if_pc, held_pc);
                check("rnd_hold_inst", if_inst, held_inst);
            end
            prev_pulse = get_inst;
            st = ($urandom_range(99) < 25);
            br = ($urandom_range(99) < 3);
            stall = {5'($urandom_range(31)), st};
            branch_flag_i = br;
            if (br) begin
                branch_target_i = $urandom;
                exp_pc = {branch_target_i[31:2], 2'b00};
            end
        end
        branch_flag_i = 1'b0;
        stall = 6'h00;
        check("rnd_progress", (pulses >= 50), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
